// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU ops,
// datapath select codes and the controller state enum.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic nop;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic legal;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Instruction decoder: opcode/funct to one-hot instruction class plus a legal flag.
module mc_ctrl_dec
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    logic rtype;

    always_comb begin
        dec       = '0;
        rtype     = (opcode == OP_RTYPE);
        dec.addu  = rtype && (funct == FN_ADDU);
        dec.subu  = rtype && (funct == FN_SUBU);
        dec.jr    = rtype && (funct == FN_JR);
        dec.nop   = rtype && (funct == FN_NOP);
        dec.ori   = (opcode == OP_ORI);
        dec.lui   = (opcode == OP_LUI);
        dec.lw    = (opcode == OP_LW);
        dec.sw    = (opcode == OP_SW);
        dec.beq   = (opcode == OP_BEQ);
        dec.jal   = (opcode == OP_JAL);
        dec.legal = dec.addu | dec.subu | dec.jr | dec.nop | dec.ori | dec.lui |
                    dec.lw | dec.sw | dec.beq | dec.jal;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: state register, retired counter and datapath control outputs.
//  state  | meaning
//  FETCH  | wait for imem_rdy, load IR and PC+4
//  DECODE | classify instruction, present ALU controls, flag illegal / retire nop
//  EXEC   | ALU op; branch/jump PC update and jal link write
//  MEM    | data memory access, hold until dmem_rdy
//  WB     | register file write
module mc_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W    = 32,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_equal,
    input  logic                imem_rdy,
    input  logic                dmem_rdy,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          npc_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_b,
    output logic                ext_op,
    output logic                reg_we,
    output logic [1:0]          reg_dst,
    output logic [1:0]          wd_sel,
    output logic                mem_we,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    dec_t             dec;
    logic [2:0]       alu_code;
    logic             src_b_c;
    logic             ext_c;
    logic             retire;

    mc_ctrl_dec u_dec (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    // ALU controls depend only on the instruction class, so they stay stable DECODE..WB.
    always_comb begin
        alu_code = ALU_ADD;
        src_b_c  = 1'b0;
        ext_c    = 1'b0;
        if (dec.subu || dec.beq) begin
            alu_code = ALU_SUB;
        end else if (dec.ori) begin
            alu_code = ALU_OR;
            src_b_c  = 1'b1;
        end else if (dec.lui) begin
            alu_code = ALU_LUI;
            src_b_c  = 1'b1;
        end else if (dec.lw || dec.sw) begin
            src_b_c  = 1'b1;
            ext_c    = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        npc_sel   = NPC_PC4;
        alu_op    = '0;
        alu_src_b = 1'b0;
        ext_op    = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        mem_we    = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        if (!reset) begin
            if (state_q != ST_FETCH) begin
                alu_op    = ALU_OP_W'(alu_code);
                alu_src_b = src_b_c;
                ext_op    = ext_c;
            end
            case (state_q)
                ST_FETCH: begin
                    ir_we = imem_rdy;
                    pc_we = imem_rdy;
                    if (imem_rdy) state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (!dec.legal) begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec.nop) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec.lw || dec.sw) begin
                        state_d = ST_MEM;
                    end else if (dec.beq) begin
                        pc_we   = alu_equal;
                        npc_sel = NPC_BR;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec.jal) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_J;
                        reg_we  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec.jr) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_RS;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec.addu || dec.subu || dec.ori || dec.lui) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_MEM: begin
                    mem_we = dec.sw;
                    if (dmem_rdy) begin
                        if (dec.lw) begin
                            state_d = ST_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = (dec.addu || dec.subu) ? DST_RD : DST_RT;
                    wd_sel  = dec.lw ? WD_MEM : WD_ALU;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule
